// File: rtl/aer_spike_encoder.sv
// AER transmit encoder: spike FIFO plus 4-phase REQ/ACK serialiser.
// Optional macro AER_TS_MARKER_EN enqueues an all-ones marker on ts_done.
module aer_spike_encoder #(
  parameter int AER_WIDTH      = 12,
  parameter int FIFO_DEPTH     = 16,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      spike_in,
  input  logic [AER_WIDTH-1:0]      spike_addr,
  input  logic                      ts_done,
  input  logic                      cnt_clr,
  output logic [AER_WIDTH-1:0]      AEROUT_ADDR,
  output logic                      AEROUT_REQ,
  input  logic                      AEROUT_ACK,
  output logic                      fifo_full,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                      busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t state, state_n;

  logic                 ack_m, ack_s;
  logic [AER_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;

  logic                 push_req;
  logic [AER_WIDTH-1:0] push_data;
  logic                 push_ok;
  logic                 pop;
  logic                 drop;
  logic                 req_n;
  logic [AER_WIDTH-1:0] addr_n;

`ifdef AER_TS_MARKER_EN
  logic mk_pend;
  logic mk_req;

  // A spike always wins the write port; the marker waits a free cycle.
  assign mk_req    = ~spike_in & (mk_pend | ts_done);
  assign push_req  = spike_in | mk_req;
  assign push_data = spike_in ? spike_addr : '1;

  // Pending marker: set when ts_done collides with a spike.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mk_pend <= 1'b0;
    end else if (spike_in) begin
      mk_pend <= mk_pend | ts_done;
    end else begin
      mk_pend <= mk_pend & ts_done;
    end
  end
`else
  logic ts_done_unused;

  assign ts_done_unused = ts_done;
  assign push_req       = spike_in;
  assign push_data      = spike_addr;
`endif

  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_ok   = push_req & ((count < DEPTH_C) | pop);
  assign drop      = push_req & ~push_ok;
  assign fifo_full = (count == DEPTH_C);
  assign busy      = (count != '0) | (state != S_IDLE);

  // Two-flop synchroniser for the asynchronous acknowledge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= AEROUT_ACK;
      ack_s <= ack_m;
    end
  end

  // FIFO storage write.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (cnt_clr) begin
        drop_cnt <= DROP_CNT_WIDTH'(1);
      end else if (!(&drop_cnt)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end else if (cnt_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  // Handshake state and registered AER outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      AEROUT_REQ  <= 1'b0;
      AEROUT_ADDR <= '0;
    end else begin
      state       <= state_n;
      AEROUT_REQ  <= req_n;
      AEROUT_ADDR <= addr_n;
    end
  end

  // Next state: load address, raise REQ a cycle later, follow ack_s.
  always_comb begin
    state_n = state;
    req_n   = AEROUT_REQ;
    addr_n  = AEROUT_ADDR;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          addr_n  = mem[rd_ptr];
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        req_n   = 1'b1;
        state_n = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (ack_s) begin
          req_n   = 1'b0;
          state_n = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!ack_s) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        req_n   = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Bench for aer_spike_encoder: scoreboard of expected AER addresses.
// Builds with or without AER_TS_MARKER_EN.
module tb_aer_spike_encoder;

  logic        CLK;
  logic        RST_N;
  logic        spike_in;
  logic [11:0] spike_addr;
  logic        ts_done;
  logic        cnt_clr;
  logic [11:0] AEROUT_ADDR;
  logic        AEROUT_REQ;
  logic        AEROUT_ACK;
  logic        fifo_full;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] sb [$];

  aer_spike_encoder #(
    .AER_WIDTH(12),
    .FIFO_DEPTH(16),
    .DROP_CNT_WIDTH(8)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .spike_in(spike_in),
    .spike_addr(spike_addr),
    .ts_done(ts_done),
    .cnt_clr(cnt_clr),
    .AEROUT_ADDR(AEROUT_ADDR),
    .AEROUT_REQ(AEROUT_REQ),
    .AEROUT_ACK(AEROUT_ACK),
    .fifo_full(fifo_full),
    .overflow(overflow),
    .drop_cnt(drop_cnt),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(logic lvl, string tag);
    int k = 0;
    while (AEROUT_REQ !== lvl && k < 60) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, 32'(AEROUT_REQ), 32'(lvl));
  endtask

  task automatic wait_idle(string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic check_head();
    if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 1);
    else chk("aer_addr", 32'(AEROUT_ADDR), 32'(sb.pop_front()));
  endtask

  task automatic serve();
    wait_req(1'b1, "req_rise");
    check_head();
    repeat (2) @(negedge CLK);
    AEROUT_ACK = 1'b1;
    wait_req(1'b0, "req_fall");
    AEROUT_ACK = 1'b0;
  endtask

  initial begin
    int k;
    RST_N      = 1'b0;
    spike_in   = 1'b0;
    spike_addr = '0;
    ts_done    = 1'b0;
    cnt_clr    = 1'b0;
    AEROUT_ACK = 1'b0;
    #3;
    chk("rst_req", 32'(AEROUT_REQ), 0);
    chk("rst_addr", 32'(AEROUT_ADDR), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Single spike: latency and handshake timing
    spike_addr = 12'h05A;
    spike_in   = 1'b1;
    sb.push_back(12'h05A);
    @(negedge CLK);
    spike_in = 1'b0;
    k = 1;
    while (!AEROUT_REQ && k < 10) begin
      @(negedge CLK);
      k++;
    end
    chk("req_latency", 32'(k), 3);
    check_head();
    repeat (2) @(negedge CLK);
    AEROUT_ACK = 1'b1;
    k = 0;
    while (AEROUT_REQ && k < 10) begin
      @(negedge CLK);
      k++;
    end
    chk("req_fall_latency", 32'(k), 3);
    AEROUT_ACK = 1'b0;
    k = 0;
    while (busy && k < 10) begin
      @(negedge CLK);
      k++;
    end
    chk("idle_latency", 32'(k), 3);

    // Burst of 20 with ACK low: 0 in flight, 1..16 buffered, 3 dropped
    for (int i = 0; i < 20; i++) begin
      spike_addr = 12'(i);
      spike_in   = 1'b1;
      if (i <= 16) sb.push_back(12'(i));
      @(negedge CLK);
    end
    spike_in = 1'b0;
    chk("burst_ovf", 32'(overflow), 1);
    chk("burst_drop", 32'(drop_cnt), 3);
    chk("burst_full", 32'(fifo_full), 1);
    chk("burst_req", 32'(AEROUT_REQ), 1);
    check_head();

    // Full FIFO: only the push on the pop edge is accepted
    AEROUT_ACK = 1'b1;
    wait_req(1'b0, "full_req_fall");
    AEROUT_ACK = 1'b0;
    for (int j = 0; j < 4; j++) begin
      spike_addr = 12'h100 + 12'(j);
      spike_in   = 1'b1;
      @(negedge CLK);
    end
    spike_in = 1'b0;
    sb.push_back(12'h103);
    chk("pp_full", 32'(fifo_full), 1);
    chk("pp_drop", 32'(drop_cnt), 6);

    // Saturation, clear, and drop-beats-clear
    spike_addr = 12'h200;
    spike_in   = 1'b1;
    repeat (300) @(negedge CLK);
    spike_in = 1'b0;
    chk("sat_drop", 32'(drop_cnt), 255);
    chk("sat_ovf", 32'(overflow), 1);
    cnt_clr = 1'b1;
    @(negedge CLK);
    cnt_clr = 1'b0;
    chk("clr_drop", 32'(drop_cnt), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_full", 32'(fifo_full), 1);
    spike_in = 1'b1;
    cnt_clr  = 1'b1;
    @(negedge CLK);
    spike_in = 1'b0;
    cnt_clr  = 1'b0;
    chk("race_drop", 32'(drop_cnt), 1);
    chk("race_ovf", 32'(overflow), 1);

    // Drain in order
    repeat (17) serve();
    wait_idle("drain_idle");
    chk("drain_sb", 32'(sb.size()), 0);

    // Reset in WAIT_HI with a buffered spike
    spike_addr = 12'h0AB;
    spike_in   = 1'b1;
    @(negedge CLK);
    spike_addr = 12'h0AC;
    @(negedge CLK);
    spike_in = 1'b0;
    wait_req(1'b1, "prerst_req");
    #2;
    RST_N = 1'b0;
    #1;
    chk("mrst_req", 32'(AEROUT_REQ), 0);
    chk("mrst_addr", 32'(AEROUT_ADDR), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    spike_addr = 12'h123;
    spike_in   = 1'b1;
    sb.push_back(12'h123);
    @(negedge CLK);
    spike_in = 1'b0;
    serve();
    wait_idle("postrst_idle");

    // Spike and ts_done together
    spike_addr = 12'h007;
    spike_in   = 1'b1;
    ts_done    = 1'b1;
    sb.push_back(12'h007);
`ifdef AER_TS_MARKER_EN
    sb.push_back(12'hFFF);
`endif
    @(negedge CLK);
    spike_in = 1'b0;
    ts_done  = 1'b0;
    serve();
`ifdef AER_TS_MARKER_EN
    serve();
`endif
    wait_idle("ts_idle");
    chk("ts_sb", 32'(sb.size()), 0);
    chk("ts_ovf", 32'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
